// File: rtl/bcd_cnt_pkg.sv
// BCD counter shared types and helpers.
// Digit limits, digit type and load clamp.
package bcd_cnt_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  function automatic bcd_t bcd_clamp(input bcd_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_counter_ndigit_cell.sv
// One BCD digit register of the N-digit counter.
// Priority: clr > ld > en; at_lim flags 9 (up) or 0 (down).
module bcd_digit_cell
  import bcd_cnt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic dir,
  input  logic ld,
  input  bcd_t ld_val,
  input  logic clr,
  output bcd_t digit,
  output logic at_lim
);

  bcd_t r_digit;

  // Digit state: clear, clamped load, or single up/down step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= BCD_ZERO;
    end else if (clr) begin
      r_digit <= BCD_ZERO;
    end else if (ld) begin
      r_digit <= bcd_clamp(ld_val);
    end else if (en) begin
      if (!dir) begin
        r_digit <= (r_digit == BCD_MAX)
                 ? BCD_ZERO : r_digit + 4'd1;
      end else begin
        r_digit <= (r_digit == BCD_ZERO)
                 ? BCD_MAX : r_digit - 4'd1;
      end
    end
  end

  assign digit  = r_digit;
  assign at_lim = dir ? (r_digit == BCD_ZERO)
                      : (r_digit == BCD_MAX);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit BCD up/down counter with tick or button step source.
// Build macro BTN_SYNC_EN adds a 2-flop btn synchronizer.
module bcd_counter_ndigit
  import bcd_cnt_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int SAT_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    btn,
  input  logic                    src_sel,
  input  logic                    direction,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    carry_out,
  output logic                    at_max,
  output logic                    at_min
);

  localparam bit SAT = (SAT_MODE != 0);

  logic                  w_btn_in;
  logic                  r_btn_d;
  logic                  w_btn_rise;
  logic                  w_step;
  logic                  w_step_eff;
  logic                  w_all_lim;
  logic                  r_carry;
  logic [NUM_DIGITS-1:0] w_at_lim;
  logic [NUM_DIGITS-1:0] w_en;

`ifdef BTN_SYNC_EN
  logic r_btn_s1;
  logic r_btn_s2;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

  assign w_btn_in = r_btn_s2;
`else
  assign w_btn_in = btn;
`endif

  // Delayed button level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_btn_d <= 1'b0;
    else     r_btn_d <= w_btn_in;
  end

  assign w_btn_rise = w_btn_in & ~r_btn_d;
  assign w_step     = src_sel ? w_btn_rise : tick;
  assign w_all_lim  = &w_at_lim;
  assign w_step_eff = w_step & ~(SAT & w_all_lim);

  // Same-cycle carry chain: digit i steps when all lower are at limit.
  always_comb begin
    logic w_run;
    w_en  = '0;
    w_run = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_en[i] = w_step_eff & w_run;
      w_run   = w_run & w_at_lim[i];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (w_en[g]),
      .dir    (direction),
      .ld     (load),
      .ld_val (load_val[4*g+:4]),
      .clr    (clear),
      .digit  (count[4*g+:4]),
      .at_lim (w_at_lim[g])
    );
  end

  // Wrap pulse; never raised when clear or load wins the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_carry <= 1'b0;
    else     r_carry <= ~SAT & w_step & w_all_lim
                      & ~clear & ~load;
  end

  assign carry_out = r_carry;

  // All-nines and all-zero flags straight from the count.
  always_comb begin
    at_max = 1'b1;
    at_min = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (count[4*i+:4] != BCD_MAX)  at_max = 1'b0;
      if (count[4*i+:4] != BCD_ZERO) at_min = 1'b0;
    end
  end

endmodule
